// File: rtl/axi_slice_isolate_pkg.sv
// Shared types and helpers for the AXI slice isolation controller.
package axi_slice_isolate_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ISOLATED = 2'd2,
        ST_WAKE     = 2'd3
    } iso_state_e;

    // Outstanding count after one cycle; a decrement at zero is ignored.
    function automatic int unsigned next_count(input int unsigned cnt,
                                               input logic        inc,
                                               input logic        dec);
        logic dec_ok;
        dec_ok = dec && (cnt != 0);
        if (inc && !dec_ok) begin
            return cnt + 1;
        end else if (!inc && dec_ok) begin
            return cnt - 1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi_outstanding_cnt.sv
// Up/down counter of in-flight transactions for one AXI direction.
module axi_outstanding_cnt
    import axi_slice_isolate_pkg::*;
#(
    parameter int unsigned MAX       = 16,
    parameter int unsigned CNT_WIDTH = $clog2(MAX + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = CNT_WIDTH'(next_count(32'(cnt_q), inc_i, dec_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

    // Flags describe the count after this cycle's update so the gate can close on the same edge.
    assign full_o  = (cnt_d == CNT_WIDTH'(MAX));
    assign empty_o = (cnt_d == '0);

endmodule

// File: rtl/axi_slice_isolate_ctrl.sv
// Gates AW/AR into the dual-clock slice, drains in-flight traffic and sequences isolation.
module axi_slice_isolate_ctrl
    import axi_slice_isolate_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 isolate_req_i,
    output logic                 isolate_ack_o,
    output logic                 isolate_o,
    output logic                 timeout_o,
    input  logic                 slv_aw_valid_i,
    output logic                 slv_aw_ready_o,
    output logic                 mst_aw_valid_o,
    input  logic                 mst_aw_ready_i,
    input  logic                 slv_ar_valid_i,
    output logic                 slv_ar_ready_o,
    output logic                 mst_ar_valid_o,
    input  logic                 mst_ar_ready_i,
    input  logic                 b_valid_i,
    input  logic                 b_ready_i,
    input  logic                 r_valid_i,
    input  logic                 r_ready_i,
    input  logic                 r_last_i,
    output logic [CNT_WIDTH-1:0] wr_outstanding_o,
    output logic [CNT_WIDTH-1:0] rd_outstanding_o
);

    localparam int unsigned DW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    iso_state_e    state_q, state_d;
    logic          gate_aw_q, gate_aw_d;
    logic          gate_ar_q, gate_ar_d;
    logic          isolate_q;
    logic          timeout_q;
    logic [DW-1:0] drain_q;

    logic aw_hs, ar_hs, b_hs, r_hs;
    logic wr_full, wr_empty, rd_full, rd_empty;
    logic drained, timeout_hit, close_gates;

    assign aw_hs = slv_aw_valid_i & mst_aw_ready_i & ~gate_aw_q;
    assign ar_hs = slv_ar_valid_i & mst_ar_ready_i & ~gate_ar_q;
    assign b_hs  = b_valid_i & b_ready_i;
    assign r_hs  = r_valid_i & r_ready_i & r_last_i;

    axi_outstanding_cnt #(
        .MAX       (MAX_OUTSTANDING),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_wr_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (aw_hs),
        .dec_i   (b_hs),
        .cnt_o   (wr_outstanding_o),
        .full_o  (wr_full),
        .empty_o (wr_empty)
    );

    axi_outstanding_cnt #(
        .MAX       (MAX_OUTSTANDING),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rd_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (ar_hs),
        .dec_i   (r_hs),
        .cnt_o   (rd_outstanding_o),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

    // Gates already closed means no new handshake can arrive, so the look-ahead empty flags are final.
    assign drained     = gate_aw_q & gate_ar_q & wr_empty & rd_empty;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (drain_q == DW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (isolate_req_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drained || timeout_hit) state_d = ST_ISOLATED;
                else if (!isolate_req_i)    state_d = ST_RUN;
            end
            ST_ISOLATED: begin
                if (!isolate_req_i) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // A gate may only arm while its channel is idle or handshaking, so a pending valid is never dropped.
    always_comb begin
        close_gates = (state_d != ST_RUN);
        gate_aw_d   = (close_gates | wr_full) & (gate_aw_q | ~slv_aw_valid_i | aw_hs);
        gate_ar_d   = (close_gates | rd_full) & (gate_ar_q | ~slv_ar_valid_i | ar_hs);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            gate_aw_q <= 1'b0;
            gate_ar_q <= 1'b0;
            isolate_q <= 1'b0;
            timeout_q <= 1'b0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            gate_aw_q <= gate_aw_d;
            gate_ar_q <= gate_ar_d;
            isolate_q <= (state_d == ST_ISOLATED);
            if (state_q == ST_DRAIN && state_d == ST_ISOLATED && !drained) begin
                timeout_q <= 1'b1;
            end else if (state_d == ST_WAKE) begin
                timeout_q <= 1'b0;
            end
            if (state_q == ST_DRAIN && state_d == ST_DRAIN) begin
                drain_q <= drain_q + 1'b1;
            end else begin
                drain_q <= '0;
            end
        end
    end

    assign mst_aw_valid_o = slv_aw_valid_i & ~gate_aw_q;
    assign slv_aw_ready_o = mst_aw_ready_i & ~gate_aw_q;
    assign mst_ar_valid_o = slv_ar_valid_i & ~gate_ar_q;
    assign slv_ar_ready_o = mst_ar_ready_i & ~gate_ar_q;

    assign isolate_o     = isolate_q;
    assign isolate_ack_o = (state_q == ST_ISOLATED);
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_axi_slice_isolate_ctrl.sv
// Self-checking bench for axi_slice_isolate_ctrl: vector table, directed corner cases, random traffic vs. reference model.
module tb_axi_slice_isolate_ctrl;

    localparam int MAXO = 16;
    localparam int CW   = 5;
    localparam int TO   = 8;

    localparam int P_RUN   = 0;
    localparam int P_DRAIN = 1;
    localparam int P_ISO   = 2;
    localparam int P_WAKE  = 3;

    logic clk = 1'b0;
    logic rst_ni;
    logic req, aw_v, aw_rdy, ar_v, ar_rdy, b_v, b_r, r_v, r_r, r_l;
    logic ack, iso, tmo, slv_aw_ready, mst_aw_valid, slv_ar_ready, mst_ar_valid;
    logic [CW-1:0] wr_cnt, rd_cnt;

    always #5 clk = ~clk;

    axi_slice_isolate_ctrl #(
        .MAX_OUTSTANDING (MAXO),
        .CNT_WIDTH       (CW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .isolate_req_i    (req),
        .isolate_ack_o    (ack),
        .isolate_o        (iso),
        .timeout_o        (tmo),
        .slv_aw_valid_i   (aw_v),
        .slv_aw_ready_o   (slv_aw_ready),
        .mst_aw_valid_o   (mst_aw_valid),
        .mst_aw_ready_i   (aw_rdy),
        .slv_ar_valid_i   (ar_v),
        .slv_ar_ready_o   (slv_ar_ready),
        .mst_ar_valid_o   (mst_ar_valid),
        .mst_ar_ready_i   (ar_rdy),
        .b_valid_i        (b_v),
        .b_ready_i        (b_r),
        .r_valid_i        (r_v),
        .r_ready_i        (r_r),
        .r_last_i         (r_l),
        .wr_outstanding_o (wr_cnt),
        .rd_outstanding_o (rd_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase, gate flags, plain integer counts.
    int m_phase, m_wr, m_rd, m_drain;
    bit m_gaw, m_gar, m_to;

    typedef struct {
        bit req;
        bit aw_v;
        bit exp_iso;
        bit exp_ack;
        bit exp_aw_ready;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int upd(input int c, input bit inc, input bit dec);
        int n;
        n = c;
        if (dec && n > 0) n = n - 1;
        if (inc) n = n + 1;
        return n;
    endfunction

    function automatic logic [16:0] dut_out();
        return {mst_aw_valid, slv_aw_ready, mst_ar_valid, slv_ar_ready, iso, ack, tmo, wr_cnt, rd_cnt};
    endfunction

    function automatic logic [16:0] model_out();
        bit i;
        i = (m_phase == P_ISO);
        return {aw_v & ~m_gaw, aw_rdy & ~m_gaw, ar_v & ~m_gar, ar_rdy & ~m_gar,
                i, i, m_to, 5'(m_wr), 5'(m_rd)};
    endfunction

    task automatic model_reset();
        m_phase = P_RUN; m_wr = 0; m_rd = 0; m_drain = 0;
        m_gaw = 0; m_gar = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit aw_hs, ar_hs;
        int nwr, nrd, np, nd;
        aw_hs = aw_v && aw_rdy && !m_gaw;
        ar_hs = ar_v && ar_rdy && !m_gar;
        nwr = upd(m_wr, aw_hs, b_v && b_r);
        nrd = upd(m_rd, ar_hs, r_v && r_r && r_l);
        np = m_phase;
        nd = 0;
        case (m_phase)
            P_RUN:   if (req) np = P_DRAIN;
            P_DRAIN: begin
                if (m_gaw && m_gar && nwr == 0 && nrd == 0) np = P_ISO;
                else if (m_drain >= TO - 1) begin np = P_ISO; m_to = 1; end
                else if (!req) np = P_RUN;
                else nd = m_drain + 1;
            end
            P_ISO:   if (!req) begin np = P_WAKE; m_to = 0; end
            default: np = P_RUN;
        endcase
        m_gaw = ((np != P_RUN) || nwr == MAXO) && (m_gaw || !aw_v || aw_hs);
        m_gar = ((np != P_RUN) || nrd == MAXO) && (m_gar || !ar_v || ar_hs);
        m_phase = np; m_wr = nwr; m_rd = nrd; m_drain = nd;
    endtask

    // Inputs are set at posedge+1; compare at +3, advance model, end at next posedge+1.
    task automatic cycle(input string name);
        #2;
        check(name, dut_out(), model_out());
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = 0; aw_v = 0; aw_rdy = 0; ar_v = 0; ar_rdy = 0;
        b_v = 0; b_r = 0; r_v = 0; r_r = 0; r_l = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        clear_inputs();
        model_reset();
        #3;
        check("reset_outputs", dut_out(), 17'h0);
        aw_rdy = 1; ar_rdy = 1;
        #1;
        check("reset_gates_open", {slv_aw_ready, slv_ar_ready}, 2'b11);
        @(posedge clk);
        #1;
        rst_ni = 1;
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{1, 0, 0, 0, 1};
        vecs[1] = '{1, 0, 0, 0, 0};
        vecs[2] = '{1, 0, 1, 1, 0};
        vecs[3] = '{0, 0, 1, 1, 0};
        vecs[4] = '{0, 0, 0, 0, 0};
        vecs[5] = '{0, 0, 0, 0, 1};
        vecs[6] = '{0, 1, 0, 0, 1};

        rst_ni = 0;
        clear_inputs();
        @(posedge clk);
        #1;

        // Idle isolate/release sequence from the vector table
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req = vecs[i].req;
            aw_v = vecs[i].aw_v;
            #2;
            check($sformatf("tbl%0d_iso", i), iso, vecs[i].exp_iso);
            check($sformatf("tbl%0d_ack", i), ack, vecs[i].exp_ack);
            check($sformatf("tbl%0d_aw_ready", i), slv_aw_ready, vecs[i].exp_aw_ready);
            check($sformatf("tbl%0d_timeout", i), tmo, 1'b0);
            cycle($sformatf("tbl%0d_model", i));
        end

        // Three writes outstanding, isolation waits for the third B
        do_reset();
        aw_v = 1;
        repeat (3) cycle("wr_fill");
        aw_v = 0; req = 1;
        cycle("wr_req");
        aw_v = 1;
        #2;
        check("wr_drain_cnt", wr_cnt, 3);
        check("wr_drain_aw_stall", slv_aw_ready, 1'b0);
        check("wr_drain_iso", iso, 1'b0);
        cycle("wr_d1");
        b_v = 1; b_r = 1;
        cycle("wr_b1");
        cycle("wr_b2");
        #2;
        check("wr_before_last_b_iso", iso, 1'b0);
        cycle("wr_b3");
        b_v = 0; b_r = 0;
        #2;
        check("wr_iso_after_b", iso, 1'b1);
        check("wr_iso_cnt", wr_cnt, 0);
        cycle("wr_iso");
        req = 0; aw_v = 0;
        repeat (3) cycle("wr_release");

        // AR pending when request arrives must not be withdrawn
        do_reset();
        ar_v = 1; ar_rdy = 0; req = 1;
        cycle("ar_req");
        #2;
        check("ar_hold_valid1", mst_ar_valid, 1'b1);
        cycle("ar_c1");
        #2;
        check("ar_hold_valid2", mst_ar_valid, 1'b1);
        cycle("ar_c2");
        ar_rdy = 1;
        cycle("ar_hs");
        r_v = 1; r_r = 1; r_l = 0;
        #2;
        check("ar_gate_closed", mst_ar_valid, 1'b0);
        check("ar_rd_cnt", rd_cnt, 1);
        cycle("ar_r_beat");
        r_l = 1;
        #2;
        check("ar_rd_cnt_nolast", rd_cnt, 1);
        cycle("ar_r_last");
        r_v = 0; r_r = 0; r_l = 0;
        #2;
        check("ar_iso", iso, 1'b1);
        check("ar_no_timeout", tmo, 1'b0);
        cycle("ar_iso_model");
        req = 0; ar_v = 0;
        repeat (3) cycle("ar_release");

        // Unanswered read forces isolation via timeout
        do_reset();
        ar_v = 1;
        cycle("to_ar");
        ar_v = 0; req = 1;
        cycle("to_req");
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin
                #2;
                check("to_not_yet", iso, 1'b0);
            end
            cycle("to_drain");
        end
        req = 0;
        #2;
        check("to_iso", iso, 1'b1);
        check("to_flag", tmo, 1'b1);
        check("to_rd_cnt", rd_cnt, 1);
        cycle("to_c9");
        #2;
        check("wake_iso_low", iso, 1'b0);
        check("wake_timeout_clr", tmo, 1'b0);
        check("wake_gate_closed", slv_ar_ready, 1'b0);
        cycle("to_wake");
        #2;
        check("wake_gates_open", slv_ar_ready, 1'b1);
        cycle("to_run");

        // Full write counter blocks the 17th AW
        do_reset();
        aw_v = 1;
        repeat (16) cycle("full_fill");
        #2;
        check("full_cnt", wr_cnt, 16);
        check("full_aw_stall", slv_aw_ready, 1'b0);
        cycle("full_hold");
        b_v = 1; b_r = 1;
        cycle("full_b");
        #2;
        check("full_reopen_cnt", wr_cnt, 15);
        check("full_reopen_ready", slv_aw_ready, 1'b1);
        cycle("full_aw_and_b");
        b_v = 0; b_r = 0;
        #2;
        check("full_same_cycle_cnt", wr_cnt, 15);
        cycle("full_refill");
        #2;
        check("full_again_cnt", wr_cnt, 16);
        check("full_again_stall", slv_aw_ready, 1'b0);
        cycle("full_end");

        // Reset asserted mid-drain returns everything to reset values
        do_reset();
        aw_v = 1;
        cycle("rst_aw");
        aw_v = 0; req = 1;
        cycle("rst_req");
        cycle("rst_drain");
        aw_v = 1;
        rst_ni = 0;
        #1;
        model_reset();
        check("rst_mid_drain", dut_out(), model_out());
        check("rst_mid_drain_cnt", wr_cnt, 0);
        check("rst_mid_drain_open", mst_aw_valid, 1'b1);

        // Random traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) req = ~req;
            aw_v   = 1'($urandom);
            aw_rdy = 1'($urandom);
            ar_v   = 1'($urandom);
            ar_rdy = 1'($urandom);
            b_v    = 1'($urandom);
            b_r    = 1'($urandom);
            r_v    = 1'($urandom);
            r_r    = 1'($urandom);
            r_l    = 1'($urandom);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
